mpsoc_ram_1r1w_bypass: RTL and testbench

Parametrised successor 1R1W RAM for the AHB3 memory subsystem. Adds a generic inferred storage array with byte-enable-exact same-address collision handling, selectable write-first/read-first semantics and selectable read latency. Gated reads hold their output, and a read-valid strobe is provided. Sits under the AHB-Lite memory slave and the cache data/tag arrays, replacing ad-hoc bypass logic around raw RAM instances.

---
 rtl/mpsoc_ram_1r1w_bypass.sv | 111 +++++++++++
 tb/tb_mpsoc_ram_1r1w_bypass.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mpsoc_ram_1r1w_bypass.sv
// 1R1W inferred RAM with byte enables, same-address collision policy and 1- or 2-cycle read latency.
// dout_o holds across idle cycles; dout_valid_o marks the cycle carrying a read result.
module mpsoc_ram_1r1w_bypass #(
    parameter int    ABITS   = 10,
    parameter int    DBITS   = 32,
    parameter int    LATENCY = 1,
    parameter string RW_MODE = "WRITE_FIRST"
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ABITS-1:0]         waddr_i,
    input  logic [DBITS-1:0]         din_i,
    input  logic                     we_i,
    input  logic [(DBITS+7)/8-1:0]   be_i,
    input  logic [ABITS-1:0]         raddr_i,
    input  logic                     re_i,
    output logic [DBITS-1:0]         dout_o,
    output logic                     dout_valid_o
);

    localparam int NBE         = (DBITS + 7) / 8;
    localparam bit WRITE_FIRST = (RW_MODE == "WRITE_FIRST");

    if ((LATENCY != 1 && LATENCY != 2) ||
        (RW_MODE != "WRITE_FIRST" && RW_MODE != "READ_FIRST")) begin : g_bad_cfg
        $error("mpsoc_ram_1r1w_bypass: LATENCY must be 1 or 2, RW_MODE WRITE_FIRST or READ_FIRST");
    end

    logic [DBITS-1:0] mem [2**ABITS];
    logic [DBITS-1:0] wmask;
    logic [DBITS-1:0] rd_word;
    logic             collision;

    // Expand byte enables to a bit mask; the top lane is clipped when DBITS is not a multiple of 8.
    for (genvar k = 0; k < NBE; k++) begin : g_lane
        localparam int LO = 8 * k;
        localparam int HI = (8 * k + 7 < DBITS) ? 8 * k + 7 : DBITS - 1;
        assign wmask[HI:LO] = {(HI - LO + 1){be_i[k]}};
    end

    assign rd_word   = mem[raddr_i];
    assign collision = we_i & re_i & (raddr_i == waddr_i);

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= (mem[waddr_i] & ~wmask) | (din_i & wmask);
        end
    end

    if (LATENCY == 1) begin : g_lat1
        logic [DBITS-1:0] fwd_word;

        always_comb begin
            fwd_word = rd_word;
            if (WRITE_FIRST && collision) begin
                fwd_word = (rd_word & ~wmask) | (din_i & wmask);
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                dout_o       <= '0;
                dout_valid_o <= 1'b0;
            end else begin
                dout_valid_o <= re_i;
                if (re_i) begin
                    dout_o <= fwd_word;
                end
            end
        end
    end else begin : g_lat2
        logic [DBITS-1:0] raw_q;
        logic [DBITS-1:0] din_q;
        logic [DBITS-1:0] mask_q;
        logic             fwd_q;
        logic             rd_vld_q;
        logic [DBITS-1:0] merged;

        // Raw word plus the colliding write are captured together so the merge happens a cycle later.
        always_ff @(posedge clk_i) begin
            if (re_i) begin
                raw_q  <= rd_word;
                din_q  <= din_i;
                mask_q <= wmask;
                fwd_q  <= WRITE_FIRST && collision;
            end
        end

        always_comb begin
            merged = raw_q;
            if (fwd_q) begin
                merged = (raw_q & ~mask_q) | (din_q & mask_q);
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                rd_vld_q     <= 1'b0;
                dout_o       <= '0;
                dout_valid_o <= 1'b0;
            end else begin
                rd_vld_q     <= re_i;
                dout_valid_o <= rd_vld_q;
                if (rd_vld_q) begin
                    dout_o <= merged;
                end
            end
        end
    end

endmodule

// File: tb/tb_mpsoc_ram_1r1w_bypass.sv
// Bench for mpsoc_ram_1r1w_bypass: five configurations share one stimulus stream and are checked
// every cycle against a scoreboard of expected results, plus literal spot checks.
module tb_mpsoc_ram_1r1w_bypass;

    localparam int NI = 5;
    localparam int AB = 4;
    localparam int LAT_C [NI] = '{1, 1, 2, 2, 1};
    localparam bit WF_C  [NI] = '{1, 0, 1, 0, 1};
    localparam int W_C   [NI] = '{32, 32, 32, 32, 36};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AB-1:0] waddr = '0;
    logic [AB-1:0] raddr = '0;
    logic [35:0]   din = '0;
    logic [4:0]    be = '0;
    logic          we = 1'b0;
    logic          re = 1'b0;

    logic [31:0]   d0, d1, d2, d3;
    logic [35:0]   d4;
    logic [NI-1:0] dv;
    logic [35:0]   dout_a [NI];

    always #5 clk = ~clk;

    mpsoc_ram_1r1w_bypass #(.ABITS(AB), .DBITS(32), .LATENCY(1), .RW_MODE("WRITE_FIRST")) u_l1_wf (
        .clk_i(clk), .rst_i(rst), .waddr_i(waddr), .din_i(din[31:0]), .we_i(we), .be_i(be[3:0]),
        .raddr_i(raddr), .re_i(re), .dout_o(d0), .dout_valid_o(dv[0]));
    mpsoc_ram_1r1w_bypass #(.ABITS(AB), .DBITS(32), .LATENCY(1), .RW_MODE("READ_FIRST")) u_l1_rf (
        .clk_i(clk), .rst_i(rst), .waddr_i(waddr), .din_i(din[31:0]), .we_i(we), .be_i(be[3:0]),
        .raddr_i(raddr), .re_i(re), .dout_o(d1), .dout_valid_o(dv[1]));
    mpsoc_ram_1r1w_bypass #(.ABITS(AB), .DBITS(32), .LATENCY(2), .RW_MODE("WRITE_FIRST")) u_l2_wf (
        .clk_i(clk), .rst_i(rst), .waddr_i(waddr), .din_i(din[31:0]), .we_i(we), .be_i(be[3:0]),
        .raddr_i(raddr), .re_i(re), .dout_o(d2), .dout_valid_o(dv[2]));
    mpsoc_ram_1r1w_bypass #(.ABITS(AB), .DBITS(32), .LATENCY(2), .RW_MODE("READ_FIRST")) u_l2_rf (
        .clk_i(clk), .rst_i(rst), .waddr_i(waddr), .din_i(din[31:0]), .we_i(we), .be_i(be[3:0]),
        .raddr_i(raddr), .re_i(re), .dout_o(d3), .dout_valid_o(dv[3]));
    mpsoc_ram_1r1w_bypass #(.ABITS(AB), .DBITS(36), .LATENCY(1), .RW_MODE("WRITE_FIRST")) u_l1_w36 (
        .clk_i(clk), .rst_i(rst), .waddr_i(waddr), .din_i(din), .we_i(we), .be_i(be),
        .raddr_i(raddr), .re_i(re), .dout_o(d4), .dout_valid_o(dv[4]));

    assign dout_a[0] = {4'h0, d0};
    assign dout_a[1] = {4'h0, d1};
    assign dout_a[2] = {4'h0, d2};
    assign dout_a[3] = {4'h0, d3};
    assign dout_a[4] = d4;

    typedef struct {
        int          inst;
        int          due;
        logic [35:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [35:0] mm [NI][2**AB];
    logic [35:0] hold [NI] = '{default: '0};
    int          ecount = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    always @(posedge clk) ecount <= ecount + 1;

    function automatic logic [35:0] lanes(input logic [4:0] b, input int w);
        logic [35:0] m;
        logic [63:0] full;
        m = '0;
        for (int k = 0; k < 5; k++) begin
            if (b[k]) m[8*k +: 8] = 8'hFF;
        end
        full = (64'h1 << w) - 64'h1;
        return m & full[35:0];
    endfunction

    // Reference behaviour for one clock edge: queue the read result due LATENCY edges later, then write.
    task automatic model_cycle();
        logic [35:0] m, old, res;
        for (int i = 0; i < NI; i++) begin
            m = lanes(be, W_C[i]);
            if (re) begin
                old = mm[i][raddr];
                res = old;
                if (WF_C[i] && we && (waddr == raddr)) res = (old & ~m) | (din & m);
                sb.push_back('{i, ecount + LAT_C[i], res});
            end
            if (we) mm[i][waddr] = (mm[i][waddr] & ~m) | (din & m);
        end
    endtask

    task automatic step(input logic w_en, input logic [AB-1:0] wa, input logic [35:0] wd,
                        input logic [4:0] b, input logic r_en, input logic [AB-1:0] ra);
        we = w_en; waddr = wa; din = wd; be = b; re = r_en; raddr = ra;
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic        ev;
        logic [35:0] ed;
        for (int i = 0; i < NI; i++) begin
            ev = 1'b0;
            ed = hold[i];
            foreach (sb[j]) begin
                if (sb[j].inst == i && sb[j].due == ecount) begin
                    ev = 1'b1;
                    ed = sb[j].data;
                end
            end
            hold[i] = ed;
            n_cmp++;
            if (dv[i] !== ev || dout_a[i] !== ed) begin
                n_err++;
                $display("FAIL sb_inst%0d edge %0d: got v=%b d=%h want v=%b d=%h",
                         i, ecount, dv[i], dout_a[i], ev, ed);
            end
        end
        for (int j = sb.size() - 1; j >= 0; j--) begin
            if (sb[j].due <= ecount) sb.delete(j);
        end
    end

    initial begin
        logic [63:0] rnd;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_dout_l1", dout_a[0], 36'h0);
        chk("reset_valid_l2", {35'h0, dv[2]}, 36'h0);
        rst = 1'b0;

        step(1'b1, 4'd5, 36'h0DEADBEEF, 5'h1F, 1'b0, '0);
        step(1'b0, '0, '0, '0, 1'b1, 4'd5);
        chk("l1_basic", dout_a[0], 36'h0DEADBEEF);
        chk("l1_basic_valid", {35'h0, dv[0]}, 36'h1);
        chk("l2_early_valid", {35'h0, dv[2]}, 36'h0);
        idle();
        chk("l2_basic", dout_a[2], 36'h0DEADBEEF);
        chk("l2_basic_valid", {35'h0, dv[2]}, 36'h1);
        chk("l1_hold", dout_a[0], 36'h0DEADBEEF);

        step(1'b1, 4'd5, 36'h011223344, 5'b00101, 1'b0, '0);
        step(1'b0, '0, '0, '0, 1'b1, 4'd5);
        chk("l1_byte_en", dout_a[0], 36'h0DE22BE44);
        step(1'b1, 4'd5, 36'hFFFFFFFFF, 5'b00000, 1'b0, '0);
        step(1'b0, '0, '0, '0, 1'b1, 4'd5);
        chk("l1_be_zero", dout_a[0], 36'h0DE22BE44);

        step(1'b1, 4'd9, 36'h0AAAAAAAA, 5'h1F, 1'b0, '0);
        step(1'b1, 4'd9, 36'h055555555, 5'b01100, 1'b1, 4'd9);
        chk("l1_coll_wf", dout_a[0], 36'h05555AAAA);
        chk("l1_coll_rf", dout_a[1], 36'h0AAAAAAAA);
        step(1'b0, '0, '0, '0, 1'b1, 4'd9);
        chk("l1_after_wf", dout_a[0], 36'h05555AAAA);
        chk("l1_after_rf", dout_a[1], 36'h05555AAAA);
        chk("l2_coll_wf", dout_a[2], 36'h05555AAAA);
        chk("l2_coll_rf", dout_a[3], 36'h0AAAAAAAA);
        step(1'b1, 4'd9, 36'h012345678, 5'h1F, 1'b0, '0);
        chk("l2_late_write_wf", dout_a[2], 36'h05555AAAA);
        chk("l2_after_rf", dout_a[3], 36'h05555AAAA);
        step(1'b0, '0, '0, '0, 1'b1, 4'd9);
        chk("l1_overwrite", dout_a[0], 36'h012345678);

        for (int a = 0; a < 4; a++) step(1'b1, AB'(a), 36'(a), 5'h1F, 1'b0, '0);
        for (int a = 0; a < 4; a++) step(1'b0, '0, '0, '0, 1'b1, AB'(a));
        chk("l2_stream_d2", dout_a[2], 36'h2);
        idle();
        chk("l2_stream_d3", dout_a[2], 36'h3);
        chk("l2_stream_v3", {35'h0, dv[2]}, 36'h1);
        idle();
        chk("l2_hold_d", dout_a[2], 36'h3);
        chk("l2_hold_v", {35'h0, dv[2]}, 36'h0);

        step(1'b0, '0, '0, '0, 1'b1, 4'd1);
        rst = 1'b1;
        sb.delete();
        hold = '{default: '0};
        #1;
        chk("rst_l2_dout", dout_a[2], 36'h0);
        chk("rst_l2_valid", {35'h0, dv[2]}, 36'h0);
        chk("rst_l1_dout", dout_a[0], 36'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        idle();
        step(1'b0, '0, '0, '0, 1'b1, 4'd1);
        idle();
        chk("l2_post_reset", dout_a[2], 36'h1);

        step(1'b1, 4'd7, 36'h0, 5'h1F, 1'b0, '0);
        step(1'b1, 4'd7, 36'hF00000000, 5'b10000, 1'b0, '0);
        step(1'b0, '0, '0, '0, 1'b1, 4'd7);
        chk("w36_top_lane", dout_a[4], 36'hF00000000);
        chk("w32_top_lane", dout_a[0], 36'h0);

        step(1'b1, 4'd2, 36'h000000077, 5'h1F, 1'b1, 4'd3);
        chk("l1_indep", dout_a[0], 36'h3);

        for (int n = 0; n < 40; n++) begin
            rnd = {$urandom, $urandom};
            step(1'($urandom_range(0, 1)), AB'($urandom_range(0, 3)), rnd[35:0],
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), AB'($urandom_range(0, 3)));
        end
        repeat (3) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
